inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter AW, default 10, instruction address width; program space is 2**AW words.
REQ-002 Parameter RUN_TIMEOUT, default 16'hFFFF, run cycles before the block forces timeout.
REQ-003 CLK  in  1  clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  host byte-stream valid.
REQ-006 in_data  in  8  host byte.
REQ-007 in_ready  out  1  block accepts byte; a byte transfers on a cycle where in_valid and in_ready are both high.
REQ-008 wr_en  out  1  instruction-RAM write strobe, one cycle per word.
REQ-009 wr_addr  out  AW  instruction-RAM write address.
REQ-010 wr_data  out  9  instruction word.
REQ-011 core_start  out  1  core init/reset, active high.
REQ-012 core_halt  in  1  core done flag.
REQ-013 busy  out  1  high in any state except IDLE and DONE.
REQ-014 done  out  1  high in DONE.
REQ-015 overflow  out  1  sticky: program exceeded 2**AW words.
REQ-016 timeout  out  1  sticky: core did not halt within RUN_TIMEOUT cycles.
REQ-017 run_cycles  out  16  cycles spent in RUN, saturating at 16'hFFFF.

Function
REQ-018 States: IDLE, LO, HI, START, RUN, DONE.
REQ-019 Word format: two bytes, low first; low byte = word[7:0]; high byte bit0 = word[8], bit7 = last flag, bits6:1 ignored.
REQ-020 IDLE: in_ready=1; an accepted byte is latched as the low byte and the state goes to HI; wr_addr resets to 0 and overflow/timeout clear on that acceptance.
REQ-021 LO: in_ready=1; an accepted byte is latched as the low byte and the state goes to HI.
REQ-022 HI: in_ready=1; acceptance drives wr_en=1 for exactly one cycle on the next cycle, with wr_data={hi[0],lo} and the current wr_addr.
REQ-023 wr_addr increments by 1 in the cycle after each write, i.e. write latency is one cycle from high-byte acceptance.
REQ-024 After HI acceptance: if last=0 and wr_addr<2**AW-1, go to LO; if last=1, go to START.
REQ-025 If last=0 at wr_addr=2**AW-1: write the word, set overflow, go to START without wrapping the address, and discard the remaining host bytes until the next IDLE acceptance.
REQ-026 in_ready=0 in START, RUN and DONE; in_valid is ignored there.
REQ-027 core_start=1 in IDLE, LO, HI and START; 0 in RUN; 1 in DONE, so the core is held in init whenever it is not running.
REQ-028 START lasts exactly 2 cycles, then goes to RUN; this guarantees the final write is committed before the core leaves init.
REQ-029 RUN: run_cycles clears on entry and increments each RUN cycle; core_halt is ignored on the first RUN cycle.
REQ-030 RUN exits to DONE on core_halt=1 (from the second RUN cycle) or when run_cycles reaches RUN_TIMEOUT; the timeout exit sets timeout.
REQ-031 DONE holds run_cycles, overflow and timeout; an accepted byte is not possible (in_ready=0); DONE goes to IDLE when in_valid=1 and in_data=8'hA5 (re-arm token), the token being consumed without in_ready.
REQ-032 Simultaneous halt and timeout in the same cycle: halt wins, timeout stays 0.
REQ-033 A word with last=1 at address 2**AW-1 is a normal end; overflow stays 0.

Reset
REQ-034 reset=1 forces IDLE on the next edge from any state and discards any partial word.
REQ-035 Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, core_start=1, busy=0, done=0, overflow=0, timeout=0, run_cycles=0.
REQ-036 A write strobe pending in the cycle reset is sampled is suppressed.

Verification
REQ-037 Load bytes 12,00,34,81 -> wr_en at addr0 data 9'h012, at addr1 data 9'h134; START for 2 cycles; core_start falls; core_halt on RUN cycle 5 -> done=1, run_cycles=5.
REQ-038 in_valid toggling every other cycle during load -> same writes, no duplicate or missing wr_en.
REQ-039 AW=2, five unterminated words -> writes at addresses 0-3 only, overflow=1, goes to START, extra bytes dropped.
REQ-040 RUN_TIMEOUT=8, core_halt never asserted -> DONE after 8 RUN cycles with timeout=1 and run_cycles=8.
REQ-041 core_halt=1 held from entry into RUN -> ignored on cycle 1, DONE after RUN cycle 2, run_cycles=2.
REQ-042 reset asserted in the cycle after the high-byte acceptance -> no wr_en, IDLE, all outputs at reset values; re-arm token A5 in DONE -> IDLE.

Source files
------------

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - host byte-stream instruction loader and core run supervisor
module inst_loader #(
  parameter int          AW          = 10,
  parameter logic [15:0] RUN_TIMEOUT = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [8:0]    wr_data,
  output logic          core_start,
  input  logic          core_halt,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          timeout,
  output logic [15:0]   run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_t        state_q, state_d;
  logic [7:0]    lo_q, lo_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          tmo_q, tmo_d;
  logic [15:0]   cyc_q, cyc_d;
  logic          start_cnt_q, start_cnt_d;
  logic          accept;
  logic          run_first;
  logic          run_expire;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LO) || (state_q == S_HI);
  assign accept   = in_valid && in_ready;

  // The first RUN cycle is the one where the freshly cleared counter still reads zero.
  assign run_first  = (cyc_q == 16'd0);
  assign run_expire = (({1'b0, cyc_q} + 17'd1) >= {1'b0, RUN_TIMEOUT});

  // Next-state and datapath updates; every _d defaults to holding its register.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    start_cnt_d = start_cnt_q;

    // Address advances the cycle after a write, but never wraps past the top word.
    if (wr_en_q && (addr_q != ADDR_MAX)) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lo_d    = in_data;
          addr_d  = '0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_HI;
        end
      end
      S_LO: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          wr_en_d = 1'b1;
          data_d  = {in_data[0], lo_q};
          if (in_data[7]) begin
            start_cnt_d = 1'b0;
            state_d     = S_START;
          end else if (addr_q == ADDR_MAX) begin
            ovf_d       = 1'b1;
            start_cnt_d = 1'b0;
            state_d     = S_START;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_START: begin
        if (start_cnt_q) begin
          cyc_d   = 16'd0;
          state_d = S_RUN;
        end else begin
          start_cnt_d = 1'b1;
        end
      end
      S_RUN: begin
        cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        if (core_halt && !run_first) begin
          state_d = S_DONE;
        end else if (run_expire) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (in_valid && (in_data == 8'hA5)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a partial word is simply forgotten.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lo_q        <= 8'd0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= 9'd0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      cyc_q       <= 16'd0;
      start_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      cyc_q       <= cyc_d;
      start_cnt_q <= start_cnt_d;
    end
  end

  // A strobe already registered when reset arrives must not reach the RAM.
  assign wr_en      = wr_en_q && !reset;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign core_start = (state_q != S_RUN);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;
  assign timeout    = tmo_q;
  assign run_cycles = cyc_q;

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - directed bench for inst_loader with a transaction-level model
module tb_inst_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 1 << AW;
  localparam int          TMO   = 8;

  typedef logic [7:0] bq_t[$];

  logic          CLK;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic          core_start;
  logic          core_halt;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          timeout;
  logic [15:0]   run_cycles;

  int total = 0;
  int bad   = 0;

  // expected writes, {addr, data}
  logic [AW+8:0] exp_q[$];

  inst_loader #(.AW(AW), .RUN_TIMEOUT(16'(TMO))) dut (
    .CLK        (CLK),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_start (core_start),
    .core_halt  (core_halt),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .timeout    (timeout),
    .run_cycles (run_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Each observed write must be the next one the model predicts; status flags must be mutually consistent.
  always @(negedge CLK) begin
    logic [AW+8:0] e;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_en", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[AW+8:9]));
        chk("wr_data", 32'(wr_data), 32'(e[8:0]));
      end
    end
    if (!core_start) chk("run_flags", 32'({core_start, busy, in_ready, done}), 32'b0100);
    if (done)        chk("done_flags", 32'({core_start, busy, in_ready, done}), 32'b1001);
  end

  // Word-level model: words are byte pairs, stored at consecutive addresses until a
  // last flag or the top of program space; only the bytes of stored words get accepted.
  task automatic model_load(input bq_t b, output int nacc, output logic ovf);
    int words;
    words = 0;
    nacc  = 0;
    ovf   = 1'b0;
    for (int i = 0; i + 1 < b.size(); i += 2) begin
      exp_q.push_back({AW'(words), b[i+1][0], b[i]});
      nacc += 2;
      if (b[i+1][7]) break;
      if (words == DEPTH - 1) begin
        ovf = 1'b1;
        break;
      end
      words++;
    end
  endtask

  task automatic load(input bq_t b, input int gap, output int acc);
    logic rdy;
    logic stop;
    acc  = 0;
    stop = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (!stop) begin
        in_valid = 1'b1;
        in_data  = b[i];
        @(negedge CLK);
        rdy = in_ready;
        step();
        in_valid = 1'b0;
        if (!rdy) begin
          stop = 1'b1;
        end else begin
          acc++;
          if (i < b.size() - 1) begin
            for (int g = 0; g < gap; g++) step();
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_phase(input int h, output int runs, output int waits);
    int guard;
    runs  = 0;
    waits = 0;
    guard = 0;
    while (core_start && guard < 50) begin
      step();
      waits++;
      guard++;
    end
    if (guard >= 50) chk("run_entry_timeout", 32'(guard), 32'd0);
    guard = 0;
    while (!core_start && guard < 100) begin
      runs++;
      core_halt = (runs >= h);
      step();
      guard++;
    end
    if (guard >= 100) chk("run_exit_timeout", 32'(guard), 32'd0);
    core_halt = 1'b0;
  endtask

  task automatic do_test(input string name, input bq_t b, input int gap, input int h, input int exp_wait);
    int   nacc_exp, nacc, runs, waits, heff, exp_run;
    logic ovf_exp, to_exp;
    model_load(b, nacc_exp, ovf_exp);
    load(b, gap, nacc);
    chk({name, "_accepted"}, 32'(nacc), 32'(nacc_exp));
    run_phase(h, runs, waits);
    if (exp_wait >= 0) chk({name, "_start_len"}, 32'(waits), 32'(exp_wait));
    heff    = (h < 2) ? 2 : h;
    exp_run = (heff < TMO) ? heff : TMO;
    to_exp  = (heff > TMO);
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_run_count"}, 32'(runs), 32'(exp_run));
    chk({name, "_run_cycles"}, 32'(run_cycles), 32'(exp_run));
    chk({name, "_timeout"}, 32'(timeout), 32'(to_exp));
    chk({name, "_overflow"}, 32'(overflow), 32'(ovf_exp));
    chk({name, "_done"}, 32'({done, busy, core_start, in_ready}), 32'b1010);
  endtask

  task automatic rearm;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    step();
    chk("rearm_wrong_token", 32'(done), 32'd1);
    in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("rearm_idle", 32'({done, busy, in_ready, core_start}), 32'b0011);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({name, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({name, "_core_start"}, 32'(core_start), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_overflow"}, 32'(overflow), 32'd0);
    chk({name, "_timeout"}, 32'(timeout), 32'd0);
    chk({name, "_run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t  b;
    int   n;
    logic o;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    core_halt = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_reset_vals("reset");

    // pin the model against hand-derived words, then run the basic load with halt on RUN cycle 5
    b = '{8'h12, 8'h00, 8'h34, 8'h81};
    model_load(b, n, o);
    chk("model_w0", 32'(exp_q[0]), 32'({2'd0, 9'h012}));
    chk("model_w1", 32'(exp_q[1]), 32'({2'd1, 9'h134}));
    chk("model_nacc", 32'(n), 32'd4);
    exp_q.delete();
    do_test("basic", b, 0, 5, 2);
    chk("basic_run_lit", 32'(run_cycles), 32'd5);
    rearm();

    // same load with in_valid toggling every other cycle
    do_test("toggle", b, 1, 5, 2);
    rearm();

    // five unterminated words into four-word space
    b = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05, 8'h00};
    do_test("ovf", b, 0, 3, -1);
    chk("ovf_lit", 32'(overflow), 32'd1);
    rearm();
    chk("ovf_held_idle", 32'(overflow), 32'd1);

    // core never halts -> timeout after 8 RUN cycles
    b = '{8'h07, 8'h80};
    do_test("tmo", b, 0, 1000, 2);
    chk("tmo_lit", 32'({timeout, run_cycles}), 32'({1'b1, 16'd8}));
    rearm();
    chk("tmo_held_idle", 32'(timeout), 32'd1);

    // halt held from RUN entry: first cycle ignored
    b = '{8'h55, 8'h01, 8'h66, 8'h80};
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_valid = 1'b0;
    chk("flags_clear_on_accept", 32'({timeout, overflow}), 32'd0);
    exp_q.push_back({2'd0, 9'h155});
    exp_q.push_back({2'd1, 9'h066});
    b = '{8'h01, 8'h66, 8'h80};
    load(b, 0, n);
    chk("held_accepted", 32'(n), 32'd3);
    run_phase(1, n, o);
    chk("held_run_count", 32'(n), 32'd2);
    chk("held_run_cycles", 32'(run_cycles), 32'd2);
    chk("held_timeout", 32'(timeout), 32'd0);
    chk("held_writes_left", 32'(exp_q.size()), 32'd0);
    rearm();

    // last flag on the top word is a normal end; halt and timeout coincide on cycle 8
    b = '{8'h0A, 8'h00, 8'h0B, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h81};
    do_test("top_last", b, 0, 8, 2);
    rearm();

    // reset the cycle after high-byte acceptance: the pending write is lost
    in_valid = 1'b1;
    in_data  = 8'h12;
    step();
    in_data = 8'h81;
    step();
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_wr_en_suppressed", 32'(wr_en), 32'd0);
    step();
    reset = 1'b0;
    check_reset_vals("rst_mid");
    step();
    step();
    chk("rst_still_idle", 32'({busy, in_ready, core_start}), 32'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
